// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multicycle RV32I core.
// Sequences fetch, decode and execute steps over a shared ALU and a single
// memory port. It inserts wait states while memory is not ready.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_LUI      = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_illegal;

    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_regwrite;
    logic       w_memwrite;
    logic       w_instr_done;
    logic       w_adrsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [1:0] w_resultsrc;

    // Only funct3[0] distinguishes beq from bne; the upper bits are ignored.
    logic       w_unused_funct3;
    assign w_unused_funct3 = ^funct3[2:1];

    // State register and sticky illegal-opcode flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == S_HALT) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state and per-state output decode, with mem_ready gating in memory states.
    always_comb begin
        w_next_state = r_state;
        w_irwrite    = 1'b0;
        w_pcwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_memwrite   = 1'b0;
        w_instr_done = 1'b0;
        w_adrsrc     = 1'b0;
        w_alusrca    = SRCA_PC;
        w_alusrcb    = SRCB_RS2;
        w_aluop      = ALU_ADD;
        w_resultsrc  = RES_ALUOUT;

        case (r_state)
            S_FETCH: begin
                w_alusrca   = SRCA_PC;
                w_alusrcb   = SRCB_FOUR;
                w_aluop     = ALU_ADD;
                w_resultsrc = RES_ALURES;
                if (mem_ready) begin
                    w_irwrite    = 1'b1;
                    w_pcwrite    = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jal target is computed here into ALUOut.
                w_alusrca = SRCA_OLDPC;
                w_alusrcb = SRCB_IMM;
                w_aluop   = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECR;
                    OP_ITYPE:     w_next_state = S_EXECI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BRANCH:    w_next_state = S_BRANCH;
                    OP_LUI:       w_next_state = S_LUI;
                    default:      w_next_state = S_HALT;
                endcase
            end
            S_MEMADR: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_IMM;
                w_aluop      = ALU_ADD;
                w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc    = 1'b1;
                w_resultsrc = RES_ALUOUT;
                if (mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_resultsrc  = RES_DATA;
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc    = 1'b1;
                w_resultsrc = RES_ALUOUT;
                if (mem_ready) begin
                    w_memwrite   = 1'b1;
                    w_instr_done = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_EXECR: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_RS2;
                w_aluop      = ALU_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_IMM;
                w_aluop      = ALU_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_resultsrc  = RES_ALUOUT;
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // Link value PC+4 comes from OldPC+4; target already sits in ALUOut.
                w_alusrca    = SRCA_OLDPC;
                w_alusrcb    = SRCB_FOUR;
                w_aluop      = ALU_ADD;
                w_resultsrc  = RES_ALUOUT;
                w_pcwrite    = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_BRANCH: begin
                // beq takes the branch on zero, bne on not-zero.
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_RS2;
                w_aluop      = ALU_SUB;
                w_resultsrc  = RES_ALUOUT;
                w_pcwrite    = zero ^ funct3[0];
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_LUI: begin
                w_resultsrc  = RES_IMM;
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Enables are forced low while reset is held; selects follow the FETCH decode.
    assign IRWrite    = w_irwrite    & reset;
    assign PCWrite    = w_pcwrite    & reset;
    assign RegWrite   = w_regwrite   & reset;
    assign MemWrite   = w_memwrite   & reset;
    assign instr_done = w_instr_done & reset;
    assign AdrSrc     = w_adrsrc;
    assign ALUSrcA    = w_alusrca;
    assign ALUSrcB    = w_alusrcb;
    assign ALUOp      = w_aluop;
    assign ResultSrc  = w_resultsrc;
    assign illegal    = r_illegal;
    assign state      = STATE_W'(r_state);

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit for the multicycle RV32I core. The block sequences the shared ALU, instruction register, PC register and unified memory port through fetch, decode and execute steps. It drives the instruction-fetch stage's `IRWrite` and every datapath mux select and write enable. It also inserts wait states while memory is not ready, so one memory port serves both instruction fetch and data access.

## Interface
Parameters:
- none; the opcode set is fixed to lw, sw, R-type, I-type ALU, jal, beq/bne, lui.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = in reset); one clock; reset is asynchronous and active-low.
- `op`  in  7  opcode field from the instruction stage (`Instruction_op`).
- `funct3`  in  3  funct3 field; only bit 0 is used, to pick beq/bne.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `IRWrite`  out  1  load the instruction register and OldPC.
- `PCWrite`  out  1  PC register write enable.
- `RegWrite`  out  1  register file write enable.
- `MemWrite`  out  1  memory write strobe.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB`  out  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `ALUOp`  out  2  ALU op: 00 = add, 01 = subtract, 10 = decode funct3/funct7.
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- `instr_done`  out  1  one-cycle pulse in the last cycle of each instruction.
- `illegal`  out  1  sticky flag: an unsupported opcode was decoded.
- `state`  out  4  current state code, for debug.

## Operation
State codes:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
- EXECR = 6, EXECI = 7, ALUWB = 8, JAL = 9, BRANCH = 10, LUI = 11, HALT = 12

Outputs are Moore per state. The only exceptions are the `mem_ready` gating and the branch `PCWrite`. Any select not listed for a state is 00/0.

State behaviour:
- FETCH: AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - When mem_ready = 1: IRWrite = 1 and PCWrite = 1, then go to DECODE.
  - Otherwise: all enables 0 and stay in FETCH.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (computes the branch/jal target into ALUOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BRANCH
  - 0110111 → LUI
  - any other opcode → HALT
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Go to MEMREAD if op = lw, otherwise MEMWRITE.
- MEMREAD: AdrSrc = 1, ResultSrc = 00. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, instr_done = 1. Go to FETCH.
- MEMWRITE: AdrSrc = 1, ResultSrc = 00. When mem_ready = 1: MemWrite = 1, instr_done = 1, go to FETCH. Otherwise MemWrite = 0 and stay.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Go to ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Go to ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, instr_done = 1. Go to FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite = 1. Go to ALUWB.
- BRANCH: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00.
  - PCWrite = zero XOR funct3[0], combinational.
  - instr_done = 1. Go to FETCH.
- LUI: ResultSrc = 11, RegWrite = 1, instr_done = 1. Go to FETCH.
- HALT: all enables 0 and `illegal` = 1. Stays in HALT until reset.

## Timing
Reset:
- While reset = 0: state = FETCH and all enables (IRWrite, PCWrite, RegWrite, MemWrite, instr_done) are forced to 0.
- Selects hold their FETCH values; `illegal` = 0.
- Reset asserted mid-instruction aborts it immediately; the next access after release is a fresh FETCH.

Latency with mem_ready held at 1:
- lw: 5 cycles.
- sw, R-type, I-type, jal: 4 cycles.
- beq/bne, lui: 3 cycles.
- Each cycle with mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.

Boundary conditions:
- The `mem_ready` gating is combinational within the current state.
- An enable never pulses twice for a single access.
- `zero` is sampled only in BRANCH.
- `op` is sampled only in DECODE and MEMADR; it must be stable from the instruction register.

## Test plan
1. Reset, then a single lw with mem_ready = 1.
   - States must run 0→1→2→3→4→0.
   - IRWrite is high only in cycle 1; RegWrite only in cycle 5; instr_done pulses once.
2. add (0110011) followed by sw.
   - add takes 4 cycles with RegWrite in ALUWB.
   - sw takes 4 cycles with MemWrite = 1 for exactly one cycle and AdrSrc = 1.
3. beq with zero = 1 and funct3 = 000, then bne with zero = 1 and funct3 = 001.
   - beq: PCWrite = 1 in BRANCH.
   - bne: PCWrite = 0 in BRANCH.
   - Each instruction takes 3 cycles.
4. FETCH with mem_ready low for 3 cycles, then high.
   - State stays 0 for 3 cycles with IRWrite = 0 and PCWrite = 0.
   - IRWrite = 1 and PCWrite = 1 in the 4th cycle only.
5. op = 1111111.
   - DECODE→HALT; `illegal` = 1 and held for 10 cycles with no enables asserted.
   - Pull reset low: state = 0 and illegal = 0.
6. Assert reset during MEMWRITE with mem_ready = 0.
   - MemWrite stays 0 and state = 0 immediately (asynchronous).
   - After release, a normal fetch resumes.
